// File: rtl/onehot_dispatch.sv
// onehot_dispatch
//   Accepts a 2-bit target code, drives the matching one-hot select line,
//   and waits for that target's acknowledge (or a timeout) before releasing
//   and accepting the next code.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   code_in/code_valid  encoded target index and its valid strobe
//   code_ready          high in IDLE (accept on valid & ready edge)
//   O1..O4              one-hot select lines (O1 = index 00), registered
//   A1..A4              per-line acknowledges
//   busy                state != IDLE
//   done / timeout      one-cycle completion pulses (ack / timeout)
//   spurious            sticky: a non-selected ack seen while driving
//   last_code           index of the most recent ack-terminated transfer
module onehot_dispatch #(
  parameter int unsigned      CNT_W   = 8,
  parameter logic [CNT_W-1:0] TIMEOUT = 8'd200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic       O1,
  output logic       O2,
  output logic       O3,
  output logic       O4,
  input  logic       A1,
  input  logic       A2,
  input  logic       A3,
  input  logic       A4,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       spurious,
  output logic [1:0] last_code
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_REL} state_t;

  // Counter value seen on the last DRIVE cycle before a timeout fires.
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - 1'b1;

  state_t           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       o_q, o_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             spur_q, spur_d;
  logic [1:0]       last_q, last_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             rel_to_q, rel_to_d;   // current RELEASE follows a timeout

  logic [3:0] a_vec;
  logic [3:0] sel_dec;
  logic       sel_ack;
  logic       other_ack;

  assign a_vec     = {A4, A3, A2, A1};
  assign sel_dec   = 4'b0001 << code_q;
  assign sel_ack   = a_vec[code_q];
  assign other_ack = |(a_vec & ~sel_dec);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    o_d      = o_q;
    done_d   = 1'b0;
    to_d     = 1'b0;
    spur_d   = spur_q;
    last_d   = last_q;
    rel_to_d = rel_to_q;
    case (state_q)
      S_IDLE: begin
        o_d = 4'b0000;
        // Handshake uses the registered ready, so the first edge after
        // reset release cannot accept.
        if (code_valid && rdy_q) begin
          code_d  = code_in;
          cnt_d   = '0;
          o_d     = 4'b0001 << code_in;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (other_ack) spur_d = 1'b1;
        // Ack is checked first so it wins over a same-cycle timeout.
        if (sel_ack) begin
          o_d      = 4'b0000;
          done_d   = 1'b1;
          last_d   = code_q;
          rel_to_d = 1'b0;
          state_d  = S_REL;
        end else if ((TIMEOUT != '0) && (cnt_q == TO_LAST)) begin
          o_d      = 4'b0000;
          to_d     = 1'b1;
          rel_to_d = 1'b1;
          state_d  = S_REL;
        end
      end
      S_REL: begin
        o_d = 4'b0000;
        if (rel_to_q || !sel_ack) state_d = S_IDLE;
      end
      default: begin
        o_d     = 4'b0000;
        state_d = S_IDLE;
      end
    endcase
    // Registered status follows the next state so it lines up with state_q.
    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      code_q   <= 2'b00;
      cnt_q    <= '0;
      o_q      <= 4'b0000;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      spur_q   <= 1'b0;
      last_q   <= 2'b00;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      rel_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      done_q   <= done_d;
      to_q     <= to_d;
      spur_q   <= spur_d;
      last_q   <= last_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      rel_to_q <= rel_to_d;
    end
  end

  assign {O4, O3, O2, O1} = o_q;
  assign code_ready = rdy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = to_q;
  assign spurious   = spur_q;
  assign last_code  = last_q;

endmodule

// File: tb/tb_onehot_dispatch.sv
// Bench for onehot_dispatch (TIMEOUT = 5): directed transfers followed by
// randomized ones, each checked against a transaction-level expectation
// (drive length = min(ack delay, TIMEOUT-1)+1, ack beats timeout, sticky
// spurious, last_code only on ack).
module tb_onehot_dispatch;
  localparam int unsigned CNT_W = 8;
  localparam int          TO    = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] code_in = 2'b00;
  logic       code_valid = 1'b0;
  logic [3:0] a_vec = 4'b0000;
  logic       code_ready, O1, O2, O3, O4, busy, done, timeout, spurious;
  logic [1:0] last_code;
  logic [3:0] o_vec;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_last = 2'b00;
  logic       exp_spur = 1'b0;

  always #5 clk = ~clk;

  onehot_dispatch #(.CNT_W(CNT_W), .TIMEOUT(8'd5)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .O1(O1), .O2(O2), .O3(O3), .O4(O4),
    .A1(a_vec[0]), .A2(a_vec[1]), .A3(a_vec[2]), .A4(a_vec[3]),
    .busy(busy), .done(done), .timeout(timeout), .spurious(spurious),
    .last_code(last_code)
  );

  assign o_vec = {O4, O3, O2, O1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, code_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_o"}, o_vec, 0);
    chk({tag, "_pulses"}, {done, timeout}, 0);
    chk({tag, "_last"}, last_code, exp_last);
    chk({tag, "_spur"}, spurious, exp_spur);
  endtask

  // One complete transfer. ack_dly: DRIVE cycle index at which the selected
  // ack rises (>= TO means never during DRIVE). hold: extra RELEASE cycles
  // the ack stays high. spur_mask: non-selected lines allowed to glitch.
  task automatic run_xfer(input logic [1:0] code, input int ack_dly, input int hold,
                          input logic [3:0] spur_mask, input bit noisy);
    logic [3:0] sel;
    int  kend;
    bit  acked;
    sel   = 4'b0001 << code;
    acked = (ack_dly < TO);
    kend  = acked ? ack_dly : TO - 1;
    chk_idle("pre");
    code_in    = code;
    code_valid = 1'b1;
    a_vec      = 4'b0000;
    tick;
    for (int k = 0; k <= kend; k++) begin
      chk("drive_o", o_vec, sel);
      chk("drive_ready", code_ready, 0);
      chk("drive_busy", busy, 1);
      chk("drive_pulses", {done, timeout}, 0);
      chk("drive_spur", spurious, exp_spur);
      code_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      code_in    = 2'($urandom);
      a_vec      = (k >= ack_dly) ? sel : 4'b0000;
      a_vec      = a_vec | (spur_mask & ~sel & ((k == 0) ? 4'hf : 4'($urandom)));
      if ((a_vec & ~sel) != 4'b0000) exp_spur = 1'b1;
      tick;
    end
    if (acked) exp_last = code;
    chk("exit_o", o_vec, 0);
    chk("exit_done", done, acked);
    chk("exit_timeout", timeout, !acked);
    chk("exit_last", last_code, exp_last);
    chk("exit_spur", spurious, exp_spur);
    chk("exit_ready", code_ready, 0);
    chk("exit_busy", busy, 1);
    if (acked) begin
      a_vec = sel;
      for (int j = 0; j < hold; j++) begin
        tick;
        chk("rel_busy", busy, 1);
        chk("rel_ready", code_ready, 0);
        chk("rel_o", o_vec, 0);
        chk("rel_pulses", {done, timeout}, 0);
      end
      a_vec = 4'b0000;
    end else begin
      // After a timeout the selected ack must not extend RELEASE.
      a_vec = sel & 4'($urandom);
    end
    tick;
    chk_idle("post");
    a_vec      = 4'b0000;
    code_valid = 1'b0;
  endtask

  initial begin
    // Reset values without any clock edge
    #1;
    chk("rst_ready", code_ready, 0);
    chk("rst_o", o_vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, timeout, spurious}, 0);
    chk("rst_last", last_code, 0);
    code_valid = 1'b1;
    tick;
    tick;
    chk("rst_hold_ready", code_ready, 0);
    chk("rst_hold_o", o_vec, 0);
    code_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    chk_idle("rel1");

    // Directed transfers
    run_xfer(2'b10, 2, 1, 4'b0000, 1'b0);   // ack after a few cycles, held one more
    run_xfer(2'b01, 99, 0, 4'b0000, 1'b0);  // timeout, last_code stays 10
    run_xfer(2'b00, 3, 0, 4'b1000, 1'b0);   // A4 glitch while O1 driven
    chk("spur_sticky", spurious, 1);
    run_xfer(2'b11, TO - 1, 0, 4'b0000, 1'b1); // ack on the timeout cycle
    run_xfer(2'b10, 7, 0, 4'b0000, 1'b1);   // timeout, last_code stays 11
    run_xfer(2'b01, 0, 2, 4'b0000, 1'b1);   // immediate ack

    // Asynchronous reset between edges mid-DRIVE
    code_in    = 2'b01;
    code_valid = 1'b1;
    tick;
    code_valid = 1'b0;
    chk("mid_o_before", o_vec, 4'b0010);
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_o", o_vec, 0);
    chk("mid_rst_ready", code_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {done, timeout, spurious}, 0);
    chk("mid_rst_last", last_code, 0);
    exp_last = 2'b00;
    exp_spur = 1'b0;
    tick;
    tick;
    chk("mid_rst_pulses", {done, timeout}, 0);
    rst_n = 1'b1;
    tick;
    chk_idle("rel2");
    run_xfer(2'b11, 1, 0, 4'b0000, 1'b0);

    // Randomized transfers
    for (int n = 0; n < 24; n++) begin
      run_xfer(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
